// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter slice: FSM state encoding and
// the default datapath width.
package counter_pkg;

    localparam int DEFAULT_BITS = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_step.sv
// Clamped decrement: produces the next count of a descending sequence,
// never going below the low bound. Purely combinational.
module down_counter_step
    import counter_pkg::*;
#(
    parameter int Bits = DEFAULT_BITS
) (
    input  logic [Bits-1:0] count_i,
    input  logic [Bits-1:0] low_i,
    input  logic [Bits-1:0] step_i,
    output logic [Bits-1:0] next_o
);

    logic [Bits-1:0] diff_s;

    // Subtract the step if it keeps us strictly above low, else land exactly on low.
    always_comb begin
        diff_s = count_i - low_i;
        next_o = low_i;
        if (diff_s > step_i) begin
            next_o = count_i - step_i;
        end else begin
            next_o = low_i;
        end
    end

endmodule

// File: rtl/down_counter.sv
// Descending sequence generator with start/ready and valid/en handshakes.
// Optional feature: define DOWN_COUNTER_ERR_EN to add err_o, which flags a
// sequence accepted with step 0 (and high != low) or with low above high.
module down_counter
    import counter_pkg::*;
#(
    parameter int Bits = DEFAULT_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            ready_o,
    input  logic [Bits-1:0] high_val_i,
    input  logic [Bits-1:0] low_val_i,
    input  logic [Bits-1:0] step_i,
    input  logic            en_i,
    output logic [Bits-1:0] count_o,
    output logic            valid_o,
    output logic            last_o,
    output logic            done_o
`ifdef DOWN_COUNTER_ERR_EN
    ,
    output logic            err_o
`endif
);

    state_t          state_r;
    logic [Bits-1:0] count_r;
    logic [Bits-1:0] high_r;
    logic [Bits-1:0] low_r;
    logic [Bits-1:0] step_r;
    logic            done_r;
    logic [Bits-1:0] next_s;
    logic            last_s;

    down_counter_step #(
        .Bits (Bits)
    ) u_step (
        .count_i (count_r),
        .low_i   (low_r),
        .step_i  (step_r),
        .next_o  (next_s)
    );

    // Final element: count reached low, or the bounds were inverted so only high is emitted.
    always_comb begin
        last_s = 1'b0;
        if (state_r == RUN) begin
            last_s = (count_r == low_r) || (low_r > high_r);
        end else begin
            last_s = 1'b0;
        end
    end

    // Sequence FSM: accept a start in IDLE, advance or finish on en in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            count_r <= {Bits{1'b0}};
            high_r  <= {Bits{1'b0}};
            low_r   <= {Bits{1'b0}};
            step_r  <= {Bits{1'b0}};
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        high_r  <= high_val_i;
                        low_r   <= low_val_i;
                        step_r  <= step_i;
                        count_r <= high_val_i;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (en_i) begin
                        if (last_s) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            count_r <= next_s;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef DOWN_COUNTER_ERR_EN
    logic err_r;

    // Capture a suspect configuration at accept time and hold it until the next accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && start_i) begin
            err_r <= ((step_i == {Bits{1'b0}}) && (high_val_i != low_val_i)) ||
                     (low_val_i > high_val_i);
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`endif

    assign ready_o = (state_r == IDLE);
    assign valid_o = (state_r == RUN);
    assign count_o = count_r;
    assign last_o  = last_s;
    assign done_o  = done_r;

endmodule
